// File: rtl/ifu_fetch.sv
// Purpose: multi-cycle instruction fetch. Takes one PC, issues one memory read and holds the result until the IDU takes it.
// Latency: PC accept at T, request at T+1, ifu_valid one cycle after the response. A misaligned PC gives ifu_valid+fault at T+1.
// Backpressure: pc_ready is low outside IDLE. The request and the held instruction stay stable until mem_req_ready / idu_ready.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_pc_valid/i_pc/o_pc_ready        PC offer from next-PC logic
//   i_flush                           redirect: abandon the current fetch
//   o_mem_req_valid/o_mem_addr/i_mem_req_ready   memory read request
//   i_mem_resp_valid/i_mem_rdata      single-cycle read data strobe
//   o_ifu_valid/o_inst/o_inst_pc/o_fault/i_idu_ready   instruction to IDU
//   o_pc_wen                          one-cycle pulse after the IDU takes an instruction
// ALIGN_BITS must be at least 1.
module ifu_fetch #(
    parameter int ADDR_W      = 32,
    parameter int INST_W      = 32,
    parameter int ALIGN_BITS  = 2,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pc_valid,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_pc_ready,
    input  logic              i_flush,
    output logic              o_mem_req_valid,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_req_ready,
    input  logic              i_mem_resp_valid,
    input  logic [INST_W-1:0] i_mem_rdata,
    output logic              o_ifu_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    output logic              o_fault,
    input  logic              i_idu_ready,
    output logic              o_pc_wen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RESP,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [INST_W-1:0]   r_inst;
    logic                r_fault;
    logic                r_pc_wen;

    logic                w_pc_hs;
    logic                w_misaligned;
    logic                w_ld_rsp;
    logic                w_retire;

    // flush is the only input allowed to reach an output combinationally.
    assign o_pc_ready   = (r_state == S_IDLE) && !i_flush;
    assign w_pc_hs      = i_pc_valid && o_pc_ready;
    assign w_misaligned = (ALIGN_CHECK != 0) && (i_pc[ALIGN_BITS-1:0] != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_ld_rsp    = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A misaligned PC never reaches memory; it is reported as a faulting instruction.
                if (w_pc_hs) begin
                    w_state_nxt = w_misaligned ? S_HOLD : S_REQ;
                end
            end
            S_REQ: begin
                if (i_flush) begin
                    w_state_nxt = S_IDLE;
                end else if (i_mem_req_ready) begin
                    w_state_nxt = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                // On flush the response is still owed: either it arrives now and is
                // dropped, or DRAIN swallows it so only one request is ever in flight.
                if (i_flush) begin
                    w_state_nxt = i_mem_resp_valid ? S_IDLE : S_DRAIN;
                end else if (i_mem_resp_valid) begin
                    w_state_nxt = S_HOLD;
                    w_ld_rsp    = 1'b1;
                end
            end
            S_DRAIN: begin
                if (i_mem_resp_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                // flush wins over idu_ready: a redirected instruction must not retire.
                if (i_flush) begin
                    w_state_nxt = S_IDLE;
                end else if (i_idu_ready) begin
                    w_state_nxt = S_IDLE;
                    w_retire    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_inst   <= '0;
            r_fault  <= 1'b0;
            r_pc_wen <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc_wen <= w_retire;
            if (w_pc_hs) begin
                r_addr <= i_pc;
                if (w_misaligned) begin
                    r_fault <= 1'b1;
                    r_inst  <= '0;
                end
            end
            if (w_ld_rsp) begin
                r_inst  <= i_mem_rdata;
                r_fault <= 1'b0;
            end
        end
    end

    // The latched PC serves as both the request address and the instruction's PC.
    assign o_mem_req_valid = (r_state == S_REQ);
    assign o_mem_addr      = r_addr;
    assign o_ifu_valid     = (r_state == S_HOLD);
    assign o_inst          = r_inst;
    assign o_inst_pc       = r_addr;
    assign o_fault         = r_fault;
    assign o_pc_wen        = r_pc_wen;

endmodule

// File: tb/tb_ifu_fetch.sv
// Purpose: self-checking bench for ifu_fetch with a scoreboard of expected instructions.
// Latency: a memory/IDU model reacts each cycle; directed sequences check exact cycle timing.
// Backpressure: memory request wait, response latency and IDU wait are programmable per fetch.
module tb_ifu_fetch;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc;
    logic        flush;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        idu_ready;
    logic        o_pc_ready, o_mem_req_valid, o_ifu_valid, o_fault, o_pc_wen;
    logic [31:0] o_mem_addr, o_inst, o_inst_pc;

    // second instance with the alignment check disabled
    logic        n_pc_valid, n_flush, n_mem_req_ready, n_mem_resp_valid, n_idu_ready;
    logic [31:0] n_pc, n_mem_rdata;
    logic        n_pc_ready, n_mem_req_valid, n_ifu_valid, n_fault, n_pc_wen;
    logic [31:0] n_mem_addr, n_inst, n_inst_pc;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t exp_q[$];

    // memory / IDU model configuration, written by the stimulus process
    int          req_wait_cfg = 0;
    int          mem_lat_cfg  = 1;
    int          idu_wait_cfg = 0;
    logic [31:0] mem_data_cfg = '0;

    // monitor state
    int          rq_cnt = 0;
    int          hv_cnt = 0;
    bit          mem_pend = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_pdata = '0;
    int          pc_wen_cnt = 0;
    int          acc_cnt = 0;

    ifu_fetch #(.ADDR_W(32), .INST_W(32), .ALIGN_BITS(2), .ALIGN_CHECK(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_pc_valid(pc_valid), .i_pc(pc), .o_pc_ready(o_pc_ready), .i_flush(flush),
        .o_mem_req_valid(o_mem_req_valid), .o_mem_addr(o_mem_addr), .i_mem_req_ready(mem_req_ready),
        .i_mem_resp_valid(mem_resp_valid), .i_mem_rdata(mem_rdata),
        .o_ifu_valid(o_ifu_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc), .o_fault(o_fault),
        .i_idu_ready(idu_ready), .o_pc_wen(o_pc_wen)
    );

    ifu_fetch #(.ADDR_W(32), .INST_W(32), .ALIGN_BITS(2), .ALIGN_CHECK(0)) dut_na (
        .i_clk(clk), .i_rst(rst),
        .i_pc_valid(n_pc_valid), .i_pc(n_pc), .o_pc_ready(n_pc_ready), .i_flush(n_flush),
        .o_mem_req_valid(n_mem_req_valid), .o_mem_addr(n_mem_addr), .i_mem_req_ready(n_mem_req_ready),
        .i_mem_resp_valid(n_mem_resp_valid), .i_mem_rdata(n_mem_rdata),
        .o_ifu_valid(n_ifu_valid), .o_inst(n_inst), .o_inst_pc(n_inst_pc), .o_fault(n_fault),
        .i_idu_ready(n_idu_ready), .o_pc_wen(n_pc_wen)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory and IDU model plus scoreboard. Inputs for a cycle are set at its
    // falling edge, then that cycle's handshakes are evaluated.
    initial begin
        bit          hs, prev_hs, prev_rw, prev_hw;
        logic [31:0] prev_addr, prev_inst, prev_ipc;
        logic        prev_fault;
        exp_t        e;
        prev_hs = 0; prev_rw = 0; prev_hw = 0;
        prev_addr = '0; prev_inst = '0; prev_ipc = '0; prev_fault = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; idu_ready = 1'b0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_rdata      = '0;
            if (mem_pend) begin
                if (mem_cnt <= 1) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = mem_pdata;
                    mem_pend       = 0;
                end else begin
                    mem_cnt--;
                end
            end
            if (o_mem_req_valid) begin
                mem_req_ready = (rq_cnt >= req_wait_cfg);
                rq_cnt++;
            end else begin
                mem_req_ready = 1'b0;
                rq_cnt = 0;
            end
            if (o_ifu_valid) begin
                idu_ready = (hv_cnt >= idu_wait_cfg);
                hv_cnt++;
            end else begin
                idu_ready = 1'b0;
                hv_cnt = 0;
            end
            if (rst) begin
                prev_hs = 0; prev_rw = 0; prev_hw = 0;
            end else begin
                chk("pc_wen", o_pc_wen, prev_hs);
                if (o_pc_wen) pc_wen_cnt++;
                if (prev_rw) begin
                    chk("req_stable_vld", o_mem_req_valid, 1);
                    chk("req_stable_addr", o_mem_addr, prev_addr);
                end
                if (prev_hw) begin
                    chk("hold_vld", o_ifu_valid, 1);
                    chk("hold_inst", o_inst, prev_inst);
                    chk("hold_pc", o_inst_pc, prev_ipc);
                    chk("hold_fault", o_fault, prev_fault);
                end
                if (o_mem_req_valid && mem_req_ready && !flush) begin
                    chk("one_outstanding", mem_pend, 0);
                    acc_cnt++;
                    mem_pend  = 1;
                    mem_cnt   = mem_lat_cfg;
                    mem_pdata = mem_data_cfg;
                end
                hs = o_ifu_valid && idu_ready && !flush;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_ifu_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_inst", o_inst, e.inst);
                        chk("sb_inst_pc", o_inst_pc, e.pc);
                        chk("sb_fault", o_fault, e.fault);
                    end
                end
                prev_hs    = hs;
                prev_rw    = o_mem_req_valid && !mem_req_ready && !flush;
                prev_hw    = o_ifu_valid && !idu_ready && !flush;
                prev_addr  = o_mem_addr;
                prev_inst  = o_inst;
                prev_ipc   = o_inst_pc;
                prev_fault = o_fault;
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_pc_ready"}, o_pc_ready, 1);
        chk({tag, "_mem_req_valid"}, o_mem_req_valid, 0);
        chk({tag, "_mem_addr"}, o_mem_addr, 0);
        chk({tag, "_ifu_valid"}, o_ifu_valid, 0);
        chk({tag, "_inst"}, o_inst, 0);
        chk({tag, "_inst_pc"}, o_inst_pc, 0);
        chk({tag, "_fault"}, o_fault, 0);
        chk({tag, "_pc_wen"}, o_pc_wen, 0);
    endtask

    // Offer a PC until accepted; returns at the start of the cycle after acceptance.
    task automatic offer_pc(input logic [31:0] a);
        bit got;
        got = 0;
        pc_valid = 1'b1;
        pc = a;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_pc_ready) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got) chk("pc_accept_timeout", 0, 1);
        step();
        pc_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit done;
        done = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        step();
        @(negedge clk);
        step();
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int rw, input int lat,
                         input int iw, input bit fault);
        exp_t e;
        req_wait_cfg = rw;
        mem_lat_cfg  = lat;
        idu_wait_cfg = iw;
        mem_data_cfg = d;
        e.inst  = fault ? 32'h0 : d;
        e.pc    = a;
        e.fault = fault;
        exp_q.push_back(e);
        offer_pc(a);
        wait_done(60);
    endtask

    initial begin
        int   wc0, ac0;
        bit   got;
        exp_t e;
        rst = 1'b1; pc_valid = 1'b0; pc = '0; flush = 1'b0;
        n_pc_valid = 1'b0; n_pc = '0; n_flush = 1'b0; n_mem_req_ready = 1'b1;
        n_mem_resp_valid = 1'b0; n_mem_rdata = '0; n_idu_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset("rst");
        step();

        // basic zero-wait fetch with exact cycle timing
        req_wait_cfg = 0; mem_lat_cfg = 1; idu_wait_cfg = 0; mem_data_cfg = 32'h0000_0413;
        e.inst = 32'h0000_0413; e.pc = 32'h8000_0000; e.fault = 1'b0;
        exp_q.push_back(e);
        pc_valid = 1'b1; pc = 32'h8000_0000;
        @(negedge clk); chk("basic_pc_ready_T", o_pc_ready, 1);
        step(); pc_valid = 1'b0;
        @(negedge clk); chk("basic_req_T1", o_mem_req_valid, 1); chk("basic_addr_T1", o_mem_addr, 32'h8000_0000);
        step();
        @(negedge clk); chk("basic_vld_T2", o_ifu_valid, 0); chk("basic_pc_ready_T2", o_pc_ready, 0);
        step();
        @(negedge clk); chk("basic_vld_T3", o_ifu_valid, 1); chk("basic_inst_T3", o_inst, 32'h0000_0413);
        chk("basic_ipc_T3", o_inst_pc, 32'h8000_0000);
        step();
        @(negedge clk); chk("basic_pc_wen_T4", o_pc_wen, 1); chk("basic_pc_ready_T4", o_pc_ready, 1);
        step();

        // backpressure on both sides
        wc0 = pc_wen_cnt; ac0 = acc_cnt;
        fetch(32'h8000_0100, 32'h00A0_0093, 3, 5, 4, 0);
        chk("bp_pc_wen_count", pc_wen_cnt - wc0, 1);
        chk("bp_request_count", acc_cnt - ac0, 1);

        // misaligned PC: fault at T+1, no memory traffic
        ac0 = acc_cnt;
        idu_wait_cfg = 0;
        e.inst = 32'h0; e.pc = 32'h8000_0002; e.fault = 1'b1;
        exp_q.push_back(e);
        offer_pc(32'h8000_0002);
        @(negedge clk); chk("mis_req", o_mem_req_valid, 0); chk("mis_vld", o_ifu_valid, 1);
        chk("mis_fault", o_fault, 1); chk("mis_inst", o_inst, 0);
        wait_done(10);
        chk("mis_no_request", acc_cnt - ac0, 0);

        // flush in WAIT_RESP, stale response must be drained
        req_wait_cfg = 0; mem_lat_cfg = 3; idu_wait_cfg = 0; mem_data_cfg = 32'hDEAD_BEEF;
        offer_pc(32'h8000_0008);
        @(negedge clk); chk("fw_req_T1", o_mem_req_valid, 1);
        step(); flush = 1'b1;
        @(negedge clk);
        step(); flush = 1'b0;
        mem_data_cfg = 32'h1234_5678; mem_lat_cfg = 1;
        e.inst = 32'h1234_5678; e.pc = 32'h8000_0010; e.fault = 1'b0;
        exp_q.push_back(e);
        pc_valid = 1'b1; pc = 32'h8000_0010;
        @(negedge clk); chk("fw_pc_ready_drain1", o_pc_ready, 0); chk("fw_vld_drain1", o_ifu_valid, 0);
        step();
        @(negedge clk); chk("fw_pc_ready_drain2", o_pc_ready, 0); chk("fw_vld_drain2", o_ifu_valid, 0);
        step();
        @(negedge clk); chk("fw_pc_ready_after", o_pc_ready, 1);
        step(); pc_valid = 1'b0;
        wait_done(40);

        // flush in WAIT_RESP in the same cycle as the response: straight back to IDLE
        req_wait_cfg = 0; mem_lat_cfg = 1; mem_data_cfg = 32'hBAAD_F00D;
        offer_pc(32'h8000_0020);
        step(); flush = 1'b1;
        @(negedge clk); chk("fr_resp_seen", mem_resp_valid, 1);
        step(); flush = 1'b0;
        @(negedge clk); chk("fr_pc_ready", o_pc_ready, 1); chk("fr_vld", o_ifu_valid, 0);
        step();

        // flush in HOLD with idu_ready high in the same cycle
        wc0 = pc_wen_cnt;
        mem_lat_cfg = 1; idu_wait_cfg = 0; mem_data_cfg = 32'h1111_2222;
        offer_pc(32'h8000_0300);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_ifu_valid) begin
                got = 1;
                break;
            end
            step();
        end
        if (!got) chk("fh_wait_timeout", 0, 1);
        flush = 1'b1;
        @(negedge clk); chk("fh_vld_before", o_ifu_valid, 1);
        step(); flush = 1'b0;
        @(negedge clk); chk("fh_vld_after", o_ifu_valid, 0); chk("fh_pc_wen", o_pc_wen, 0);
        chk("fh_pc_ready", o_pc_ready, 1);
        step();
        @(negedge clk); chk("fh_pc_wen_count", pc_wen_cnt - wc0, 0);
        step();

        // flush with pc_valid in IDLE: PC is refused
        pc_valid = 1'b1; pc = 32'h8000_0500; flush = 1'b1;
        @(negedge clk); chk("fi_pc_ready", o_pc_ready, 0);
        step(); pc_valid = 1'b0; flush = 1'b0;
        @(negedge clk); chk("fi_req", o_mem_req_valid, 0); chk("fi_vld", o_ifu_valid, 0);
        step();

        // flush in REQ while memory is stalling
        ac0 = acc_cnt;
        req_wait_cfg = 3;
        offer_pc(32'h8000_0400);
        flush = 1'b1;
        @(negedge clk); chk("fq_req_before", o_mem_req_valid, 1);
        step(); flush = 1'b0;
        @(negedge clk); chk("fq_req_after", o_mem_req_valid, 0); chk("fq_pc_ready", o_pc_ready, 1);
        chk("fq_no_accept", acc_cnt - ac0, 0);
        step();

        // reset in WAIT_RESP; the late response must be ignored
        req_wait_cfg = 0; mem_lat_cfg = 4; mem_data_cfg = 32'h5555_AAAA;
        offer_pc(32'h8000_0200);
        step(); rst = 1'b1;
        @(negedge clk);
        step(); rst = 1'b0;
        @(negedge clk); check_reset("mid_rst");
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            chk("rst_late_vld", o_ifu_valid, 0);
            chk("rst_late_req", o_mem_req_valid, 0);
        end
        step();

        // ALIGN_CHECK=0: misaligned PC is fetched normally
        n_pc_valid = 1'b1; n_pc = 32'h8000_0002;
        @(negedge clk); chk("na_pc_ready", n_pc_ready, 1);
        step(); n_pc_valid = 1'b0;
        @(negedge clk); chk("na_req", n_mem_req_valid, 1); chk("na_addr", n_mem_addr, 32'h8000_0002);
        step(); n_mem_resp_valid = 1'b1; n_mem_rdata = 32'hCAFE_F00D;
        @(negedge clk); chk("na_vld_early", n_ifu_valid, 0);
        step(); n_mem_resp_valid = 1'b0;
        @(negedge clk); chk("na_vld", n_ifu_valid, 1); chk("na_inst", n_inst, 32'hCAFE_F00D);
        chk("na_fault", n_fault, 0); chk("na_ipc", n_inst_pc, 32'h8000_0002);
        step();
        @(negedge clk); chk("na_pc_wen", n_pc_wen, 1);
        step();

        // assorted aligned fetches with varied stalls
        for (int i = 0; i < 6; i++) begin
            fetch($urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 2), $urandom_range(1, 3),
                  $urandom_range(0, 2), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
